// File: rtl/aes_key_gen_core.sv
// -----------------------------------------------------------------------------
// aes_key_gen_core
// AES-128 key-expansion engine. Holds the current 128-bit round key and derives
// the next round key in a single clock. SubWord is done by an external shared
// S-box (Sub_o out, Sub_i back in the same cycle), and the round constant comes
// from an external Rcon source indexed by r_con_ctrl.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   nrst       : synchronous reset, active-high (1 = reset)
//   en         : global enable, 0 holds all state
//   gen_key    : load key_i as the round-0 key
//   next_rnd   : advance to the next round key (ignored once round 10 is reached)
//   key_i      : cipher key, w0 = [127:96] .. w3 = [31:0]
//   Sub_i      : SubWord(Sub_o) from the external S-box
//   r_con_i    : Rcon byte for the round selected by r_con_ctrl
//   Sub_o      : RotWord(w3) of the current key, to the external S-box
//   r_con_ctrl : round index to the Rcon source, {4'h0, round}
//   key_o      : current round key (registered)
// -----------------------------------------------------------------------------
module aes_key_gen_core (
   input  logic         clk,
   input  logic         nrst,
   input  logic         en,
   input  logic         gen_key,
   input  logic         next_rnd,
   input  logic [127:0] key_i,
   input  logic [31:0]  Sub_i,
   input  logic [7:0]   r_con_i,
   output logic [31:0]  Sub_o,
   output logic [7:0]   r_con_ctrl,
   output logic [127:0] key_o
);

   localparam logic [3:0] LAST_ROUND = 4'd10;

   logic [127:0] key_reg;
   logic [127:0] key_next;
   logic [3:0]   round_reg;
   logic [3:0]   round_next;

   logic [31:0]  temp;
   logic [31:0]  w [4];
   logic [31:0]  n [4];
   logic [127:0] key_step;

   // g(w3) = SubWord(RotWord(w3)) ^ Rcon; the S-box lookup happens outside.
   assign temp = Sub_i ^ {r_con_i, 24'h0};

   // Split the key into words and build the chained XOR n[i] = w[i] ^ n[i-1].
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_word
         assign w[gi] = key_reg[127-32*gi -: 32];
         if (gi == 0) begin : g_first
            assign n[gi] = w[gi] ^ temp;
         end else begin : g_rest
            assign n[gi] = w[gi] ^ n[gi-1];
         end
         assign key_step[127-32*gi -: 32] = n[gi];
      end
   endgenerate

   // Load beats advance; advance saturates at round 10 rather than wrapping.
   always_comb begin
      key_next   = key_reg;
      round_next = round_reg;
      if (en) begin
         if (gen_key) begin
            key_next   = key_i;
            round_next = 4'd0;
         end else if (next_rnd && (round_reg < LAST_ROUND)) begin
            key_next   = key_step;
            round_next = round_reg + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         key_reg   <= '0;
         round_reg <= '0;
      end else begin
         key_reg   <= key_next;
         round_reg <= round_next;
      end
   end

   // Outputs depend only on registered state, never on inputs.
   assign Sub_o      = {w[3][23:0], w[3][31:24]};
   assign r_con_ctrl = {4'h0, round_reg};
   assign key_o      = key_reg;

endmodule

// File: tb/tb_aes_key_gen_core.sv
// -----------------------------------------------------------------------------
// tb_aes_key_gen_core
// Directed self-checking bench for aes_key_gen_core. Each scenario task drives
// stimulus and compares outputs against hand-computed or independently modelled
// values (FIPS-197 key schedule with a local S-box and Rcon table).
// -----------------------------------------------------------------------------
module tb_aes_key_gen_core;

   logic         clk = 1'b0;
   logic         nrst;
   logic         en;
   logic         gen_key;
   logic         next_rnd;
   logic [127:0] key_i;
   logic [31:0]  Sub_i;
   logic [7:0]   r_con_i;
   logic [31:0]  Sub_o;
   logic [7:0]   r_con_ctrl;
   logic [127:0] key_o;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:9][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   aes_key_gen_core dut (
      .clk        (clk),
      .nrst       (nrst),
      .en         (en),
      .gen_key    (gen_key),
      .next_rnd   (next_rnd),
      .key_i      (key_i),
      .Sub_i      (Sub_i),
      .r_con_i    (r_con_i),
      .Sub_o      (Sub_o),
      .r_con_ctrl (r_con_ctrl),
      .key_o      (key_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

   // Textbook AES-128 expansion step: w[i+4] = w[i] ^ w[i+3] (with g() for i=0).
   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] a0, a1, a2, a3;
      a0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
      a1 = k[95:64] ^ a0;
      a2 = k[63:32] ^ a1;
      a3 = k[31:0]  ^ a2;
      return {a0, a1, a2, a3};
   endfunction

   // Advance one clock; inputs and samples live 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      nrst     = 1'b0;
      en       = 1'b1;
      gen_key  = 1'b0;
      next_rnd = 1'b0;
      key_i    = {$urandom, $urandom, $urandom, $urandom};
      Sub_i    = $urandom;
      r_con_i  = 8'($urandom);
   endtask

   task automatic load_key(input logic [127:0] k);
      idle_inputs();
      gen_key = 1'b1;
      key_i   = k;
      step();
      gen_key = 1'b0;
   endtask

   task automatic test_reset();
      // Put non-zero state in first so reset has something to clear.
      idle_inputs();
      nrst = 1'b1;
      step();
      load_key(FIPS_KEY);
      idle_inputs();
      nrst     = 1'b1;
      gen_key  = 1'b1;
      next_rnd = 1'b1;
      step();
      checks++;
      if (key_o !== 128'h0) begin
         errors++;
         $display("FAIL reset_key: got %h want %h", key_o, 128'h0);
      end
      checks++;
      if (Sub_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_sub: got %h want %h", Sub_o, 32'h0);
      end
      checks++;
      if (r_con_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL reset_rcon_ctrl: got %h want %h", r_con_ctrl, 8'h00);
      end
      $display("reset: key_o=%h Sub_o=%h r_con_ctrl=%h", key_o, Sub_o, r_con_ctrl);
      idle_inputs();
   endtask

   task automatic test_load();
      load_key(FIPS_KEY);
      checks++;
      if (key_o !== FIPS_KEY) begin
         errors++;
         $display("FAIL load_key: got %h want %h", key_o, FIPS_KEY);
      end
      checks++;
      if (Sub_o !== 32'hcf4f3c09) begin
         errors++;
         $display("FAIL load_sub: got %h want %h", Sub_o, 32'hcf4f3c09);
      end
      checks++;
      if (r_con_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL load_rcon_ctrl: got %h want %h", r_con_ctrl, 8'h00);
      end
      $display("load: key_o=%h Sub_o=%h", key_o, Sub_o);
   endtask

   task automatic test_round1();
      idle_inputs();
      next_rnd = 1'b1;
      Sub_i    = 32'h8a84eb01;
      r_con_i  = 8'h01;
      step();
      next_rnd = 1'b0;
      checks++;
      if (key_o !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605) begin
         errors++;
         $display("FAIL round1_key: got %h want %h", key_o,
                  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      end
      checks++;
      if (r_con_ctrl !== 8'h01) begin
         errors++;
         $display("FAIL round1_rcon_ctrl: got %h want %h", r_con_ctrl, 8'h01);
      end
      checks++;
      if (Sub_o !== 32'h6c76052a) begin
         errors++;
         $display("FAIL round1_sub: got %h want %h", Sub_o, 32'h6c76052a);
      end
      $display("round1: key_o=%h r_con_ctrl=%h Sub_o=%h", key_o, r_con_ctrl, Sub_o);
   endtask

   task automatic test_zero_key();
      load_key(128'h0);
      checks++;
      if (Sub_o !== 32'h0) begin
         errors++;
         $display("FAIL zero_sub: got %h want %h", Sub_o, 32'h0);
      end
      idle_inputs();
      next_rnd = 1'b1;
      Sub_i    = 32'h63636363;
      r_con_i  = 8'h01;
      step();
      next_rnd = 1'b0;
      checks++;
      if (key_o !== {4{32'h62636363}}) begin
         errors++;
         $display("FAIL zero_round1: got %h want %h", key_o, {4{32'h62636363}});
      end
      $display("zero key: key_o=%h", key_o);
   endtask

   task automatic test_rotation_hold();
      logic [127:0] k2;
      load_key(128'h4c5d2f00);
      checks++;
      if (Sub_o !== 32'h5d2f004c) begin
         errors++;
         $display("FAIL rotate_sub: got %h want %h", Sub_o, 32'h5d2f004c);
      end
      // Disabled: neither advance nor load may take effect.
      idle_inputs();
      en       = 1'b0;
      next_rnd = 1'b1;
      step();
      en       = 1'b0;
      next_rnd = 1'b0;
      gen_key  = 1'b1;
      step();
      checks++;
      if (key_o !== 128'h4c5d2f00) begin
         errors++;
         $display("FAIL hold_en_key: got %h want %h", key_o, 128'h4c5d2f00);
      end
      checks++;
      if (r_con_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL hold_en_round: got %h want %h", r_con_ctrl, 8'h00);
      end
      // Enabled with no command and garbage on the S-box/Rcon inputs.
      idle_inputs();
      step();
      checks++;
      if (key_o !== 128'h4c5d2f00) begin
         errors++;
         $display("FAIL hold_idle_key: got %h want %h", key_o, 128'h4c5d2f00);
      end
      // Load and advance together: load wins.
      k2 = 128'h01234567_89abcdef_fedcba98_76543210;
      idle_inputs();
      gen_key  = 1'b1;
      next_rnd = 1'b1;
      key_i    = k2;
      step();
      gen_key  = 1'b0;
      next_rnd = 1'b0;
      checks++;
      if (key_o !== k2) begin
         errors++;
         $display("FAIL load_wins_key: got %h want %h", key_o, k2);
      end
      checks++;
      if (r_con_ctrl !== 8'h00) begin
         errors++;
         $display("FAIL load_wins_round: got %h want %h", r_con_ctrl, 8'h00);
      end
      $display("rotation/hold: Sub_o=%h key_o=%h", Sub_o, key_o);
   endtask

   task automatic test_full_schedule();
      logic [127:0] model;
      model = FIPS_KEY;
      load_key(FIPS_KEY);
      for (int r = 0; r < 10; r++) begin
         checks++;
         if (Sub_o !== rot_word(model[31:0])) begin
            errors++;
            $display("FAIL sched_sub r%0d: got %h want %h", r, Sub_o, rot_word(model[31:0]));
         end
         // Freeze mid-sequence; the next enabled step must resume cleanly.
         if (r == 5) begin
            idle_inputs();
            en       = 1'b0;
            next_rnd = 1'b1;
            step();
            checks++;
            if (key_o !== model || r_con_ctrl !== 8'(r)) begin
               errors++;
               $display("FAIL sched_freeze: got %h/%h want %h/%h",
                        key_o, r_con_ctrl, model, 8'(r));
            end
         end
         idle_inputs();
         next_rnd = 1'b1;
         Sub_i    = sub_word(rot_word(model[31:0]));
         r_con_i  = RCON[r];
         step();
         next_rnd = 1'b0;
         model    = expand(model, RCON[r]);
         checks++;
         if (key_o !== model) begin
            errors++;
            $display("FAIL sched_key r%0d: got %h want %h", r + 1, key_o, model);
         end
         checks++;
         if (r_con_ctrl !== 8'(r + 1)) begin
            errors++;
            $display("FAIL sched_rcon_ctrl r%0d: got %h want %h", r + 1, r_con_ctrl, 8'(r + 1));
         end
         $display("schedule round %0d: key_o=%h", r + 1, key_o);
      end
      checks++;
      if (key_o !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) begin
         errors++;
         $display("FAIL sched_final: got %h want %h", key_o,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      end
      // Eleventh advance is ignored.
      idle_inputs();
      next_rnd = 1'b1;
      step();
      next_rnd = 1'b0;
      checks++;
      if (key_o !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) begin
         errors++;
         $display("FAIL sched_sat_key: got %h want %h", key_o,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      end
      checks++;
      if (r_con_ctrl !== 8'h0a) begin
         errors++;
         $display("FAIL sched_sat_round: got %h want %h", r_con_ctrl, 8'h0a);
      end
      $display("schedule round 11 attempt: key_o=%h r_con_ctrl=%h", key_o, r_con_ctrl);
   endtask

   initial begin
      idle_inputs();
      #1;
      test_reset();
      test_load();
      test_round1();
      test_zero_key();
      test_rotation_hold();
      test_full_schedule();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
